// File: rtl/ptos_pkg.sv
// Shared definitions for the multi-lane parallel-to-serial transmitter.
package ptos_pkg;
  localparam logic [7:0] COM_SYM   = 8'hBC;
  localparam int         MAX_LANES = 8;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/ptos_lane.sv
// One serial lane: a shift register that loads a whole symbol and emits
// its first bit on the same edge, then shifts out one bit per edge.
module ptos_lane #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE      = 8'hBC,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word,
  output logic             out
);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic             out_q, out_d;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    sh_d  = sh_q;
    out_d = out_q;
    if (load) begin
      out_d = first_bit(word);
      sh_d  = advance(word);
    end else if (shift) begin
      out_d = first_bit(sh_q);
      sh_d  = advance(sh_q);
    end else begin
      sh_d  = sh_q;
      out_d = out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= IDLE;
      out_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/ptos_nlane.sv
// Multi-lane parallel-to-serial converter: training FSM, shared bit counter,
// one-word holding buffer with valid/ready handshake, and per-lane shifters.
module ptos_nlane
  import ptos_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 1,
  parameter logic [WIDTH-1:0] IDLE       = WIDTH'(COM_SYM),
  parameter int               TRAIN_SYMS = 4,
  parameter bit               MSB_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES-1:0]       out,
  output logic                   out_s,
  output logic                   out_data,
  output logic                   active
);

  localparam int              BW          = $clog2(WIDTH);
  localparam int              LW          = LANES * WIDTH;
  localparam logic [BW-1:0]   BCNT_LAST   = BW'(WIDTH - 1);
  localparam logic [7:0]      TCNT_LAST   = 8'(TRAIN_SYMS - 1);
  localparam logic [7:0]      TCNT_SAT    = 8'(TRAIN_SYMS);
  localparam state_e          RESET_STATE = (TRAIN_SYMS == 0) ? RUN : TRAIN;

  state_e          state_q, state_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [7:0]      tcnt_q, tcnt_d;
  logic [LW-1:0]   buf_q, buf_d;
  logic            buf_v_q, buf_v_d;
  logic            out_s_q, out_s_d;
  logic            out_data_q, out_data_d;
  logic            sym_start, sym_last, accept, drain;
  logic [LW-1:0]   load_word;

  always_comb begin
    sym_start  = (bcnt_q == {BW{1'b0}});
    sym_last   = (bcnt_q == BCNT_LAST);
    in_ready   = ~reset & (~buf_v_q | ((state_q == RUN) & sym_start));
    accept     = in_valid & in_ready;
    drain      = (state_q == RUN) & sym_start & buf_v_q;
    load_word  = drain ? buf_q : {LANES{IDLE}};

    if (sym_last) begin
      bcnt_d = {BW{1'b0}};
    end else begin
      bcnt_d = bcnt_q + {{(BW-1){1'b0}}, 1'b1};
    end

    // Training ends on the last bit of the final forced idle symbol.
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      TRAIN: begin
        if (sym_last) begin
          if (tcnt_q < TCNT_SAT) begin
            tcnt_d = tcnt_q + 8'd1;
          end else begin
            tcnt_d = tcnt_q;
          end
          if (tcnt_q == TCNT_LAST) begin
            state_d = RUN;
          end else begin
            state_d = TRAIN;
          end
        end else begin
          state_d = TRAIN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RESET_STATE;
    endcase

    // Drain and refill may coincide; the new word replaces the drained one.
    if (accept) begin
      buf_d   = in;
      buf_v_d = 1'b1;
    end else begin
      buf_d   = buf_q;
      buf_v_d = buf_v_q & ~drain;
    end

    out_s_d = sym_start;
    if (sym_start) begin
      out_data_d = drain;
    end else begin
      out_data_d = out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      bcnt_q     <= {BW{1'b0}};
      tcnt_q     <= 8'd0;
      buf_q      <= {LW{1'b0}};
      buf_v_q    <= 1'b0;
      out_s_q    <= 1'b0;
      out_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
      buf_q      <= buf_d;
      buf_v_q    <= buf_v_d;
      out_s_q    <= out_s_d;
      out_data_q <= out_data_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ptos_lane #(
      .WIDTH     (WIDTH),
      .IDLE      (IDLE),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (sym_start),
      .shift (~sym_start),
      .word  (load_word[i*WIDTH +: WIDTH]),
      .out   (out[i])
    );
  end

  assign out_s    = out_s_q;
  assign out_data = out_data_q;
  assign active   = (state_q == RUN);

endmodule

// File: tb/tb_ptos_nlane.sv
// Bench for ptos_nlane: directed table checks on three configurations plus a
// randomized run of the two-lane configuration against a symbol-level model.
module tb_ptos_nlane;
  localparam int         W    = 8;
  localparam int         T    = 2;
  localparam logic [7:0] IDLE = 8'hBC;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A: WIDTH 8, 2 lanes, 2 training symbols, MSB first
  logic        rst_a, valid_a, ready_a, s_a, d_a, act_a;
  logic [15:0] in_a;
  logic [1:0]  out_a;
  ptos_nlane #(.WIDTH(8), .LANES(2), .IDLE(8'hBC), .TRAIN_SYMS(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(rst_a), .in(in_a), .in_valid(valid_a), .in_ready(ready_a),
    .out(out_a), .out_s(s_a), .out_data(d_a), .active(act_a));

  // B: LSB first, one lane
  logic       rst_b, valid_b, ready_b, s_b, d_b, act_b;
  logic [7:0] in_b;
  logic [0:0] out_b;
  ptos_nlane #(.WIDTH(8), .LANES(1), .IDLE(8'hBC), .TRAIN_SYMS(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(rst_b), .in(in_b), .in_valid(valid_b), .in_ready(ready_b),
    .out(out_b), .out_s(s_b), .out_data(d_b), .active(act_b));

  // C: no training
  logic       rst_c, valid_c, ready_c, s_c, d_c, act_c;
  logic [7:0] in_c;
  logic [0:0] out_c;
  ptos_nlane #(.WIDTH(8), .LANES(1), .IDLE(8'hBC), .TRAIN_SYMS(0), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset(rst_c), .in(in_c), .in_valid(valid_c), .in_ready(ready_c),
    .out(out_c), .out_s(s_c), .out_data(d_c), .active(act_c));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         e;
    logic [1:0] o;
    logic       s;
    logic       d;
    logic       a;
    logic       r;
  } vec_t;
  vec_t tbl[12];

  logic [1:0] rec_out[32];
  logic       rec_s[32], rec_d[32], rec_a[32], rec_r[32];
  logic       bb[32], cb[32], cd[32];

  // Symbol-level reference model for instance A
  int         mt;
  logic [15:0] mq[$];
  logic [15:0] m_cur;
  logic       m_cd, m_s, last_acc;
  logic [1:0] m_out;

  task automatic step(input logic r, input logic v, input logic [15:0] d);
    logic exp_rdy;
    int   b;
    rst_a = r; valid_a = v; in_a = d;
    #1;
    exp_rdy = !r && (mq.size() == 0 || (mt >= T*W && (mt % W) == 0));
    chk($sformatf("in_ready t=%0d", mt), {31'd0, ready_a}, {31'd0, exp_rdy});
    last_acc = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      mt = 0;
      mq.delete();
      m_out = 2'b00; m_s = 1'b0; m_cd = 1'b0; m_cur = {2{IDLE}};
    end else begin
      b = mt % W;
      if (b == 0) begin
        if (mt >= T*W && mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_cd  = 1'b1;
        end else begin
          m_cur = {2{IDLE}};
          m_cd  = 1'b0;
        end
      end
      m_s = (b == 0);
      for (int l = 0; l < 2; l++) m_out[l] = m_cur[l*W + (W-1-b)];
      if (last_acc) mq.push_back(d);
      mt++;
    end
    @(negedge clk);
    chk($sformatf("outputs t=%0d {out,s,data,active}", mt), {27'd0, out_a, s_a, d_a, act_a},
        {27'd0, m_out, m_s, m_cd, (mt >= T*W)});
  endtask

  logic [7:0]  byte_bi, byte_bd, byte_ci, byte_cd;
  logic [15:0] words[3];
  int          idx;
  logic        found;

  initial begin
    tbl[0]  = '{0,  2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{7,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8,  2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{15, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{16, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{17, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{18, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{19, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{20, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{23, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{24, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_a = 1'b1; valid_a = 1'b0; in_a = 16'h0;
    rst_b = 1'b1; valid_b = 1'b0; in_b = 8'h0;
    rst_c = 1'b1; valid_c = 1'b0; in_c = 8'h0;
    mt = 0; m_cur = {2{IDLE}}; m_cd = 1'b0; m_s = 1'b0; m_out = 2'b00; last_acc = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset A {out,s,data,active,ready}", {27'd0, out_a, s_a, d_a, act_a, ready_a}, 32'd0);
    chk("reset C active", {31'd0, act_c}, 32'd1);
    chk("reset C ready", {31'd0, ready_c}, 32'd0);

    // Early data on A, LSB-first on B, zero training on C, all offered at e0
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    valid_a = 1'b1; in_a = 16'hCCEE;
    valid_b = 1'b1; in_b = 8'hEE;
    valid_c = 1'b1; in_c = 8'hAA;
    #1;
    chk("e0 ready B", {31'd0, ready_b}, 32'd1);
    chk("e0 ready C", {31'd0, ready_c}, 32'd1);
    for (int e = 0; e < 32; e++) begin
      rec_r[e] = ready_a;
      @(posedge clk);
      @(negedge clk);
      rec_out[e] = out_a; rec_s[e] = s_a; rec_d[e] = d_a; rec_a[e] = act_a;
      bb[e] = out_b[0]; cb[e] = out_c[0]; cd[e] = d_c;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      #1;
    end
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl e%0d out", tbl[i].e), {30'd0, rec_out[tbl[i].e]}, {30'd0, tbl[i].o});
      chk($sformatf("tbl e%0d {s,data,active,ready}", tbl[i].e),
          {28'd0, rec_s[tbl[i].e], rec_d[tbl[i].e], rec_a[tbl[i].e], rec_r[tbl[i].e]},
          {28'd0, tbl[i].s, tbl[i].d, tbl[i].a, tbl[i].r});
    end
    for (int j = 0; j < 8; j++) begin
      byte_bi[7-j] = bb[j];
      byte_bd[7-j] = bb[16+j];
      byte_ci[7-j] = cb[j];
      byte_cd[7-j] = cb[8+j];
    end
    chk("lsb idle bits", {24'd0, byte_bi}, 32'h3D);
    chk("lsb data bits", {24'd0, byte_bd}, 32'h77);
    chk("notrain idle bits", {24'd0, byte_ci}, 32'hBC);
    chk("notrain data bits", {24'd0, byte_cd}, 32'hAA);
    chk("notrain data flag e7/e8", {30'd0, cd[7], cd[8]}, 32'd1);

    // Model-checked sequences on A: training, back-to-back, mid-symbol reset, random
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0);

    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    idx = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, idx < 3, (idx < 3) ? words[idx] : 16'h0);
      if (last_acc) idx++;
    end
    chk("back-to-back words accepted", idx, 3);

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (mt >= T*W && (mt % W) == 3 && mq.size() == 1 && m_cd) found = 1'b1;
      else step(1'b0, 1'b1, 16'(($urandom() & 32'hFFFF)));
    end
    chk("mid-symbol reset point reached", {31'd0, found}, 32'd1);
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
           16'(($urandom() & 32'hFFFF)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ptos_nlane.md
# ptos_nlane

Parametrised multi-lane parallel-to-serial converter, successor to the fixed 8-bit single-lane `ptos`. It converts `LANES` parallel words of `WIDTH` bits into one serial bit stream per lane on a single clock, accepting words through a valid/ready handshake with a one-word holding buffer. Whenever no data is pending it fills the stream with an `IDLE` symbol, and it sends a programmable training preamble after reset. It sits on the transmit side of the physical layer, after byte striping and before the line driver.

## Interface
- `WIDTH`, 8: symbol width in bits, 2..32.
- `LANES`, 1: number of lanes, 1..8; all lanes share timing and handshake.
- `IDLE`, 8'hBC: `WIDTH`-bit fill symbol (COM) sent when no data is pending.
- `TRAIN_SYMS`, 4: number of `IDLE` symbols forced after reset before data may be sent, 0..255.
- `MSB_FIRST`, 1: 1 sends bit `WIDTH-1` first, 0 sends bit 0 first.

Ports (one clock; `reset` is synchronous and active-high):
- `clk` in 1: single clock; one serial bit per lane per edge.
- `reset` in 1: synchronous, active-high.
- `in` in `LANES*WIDTH`: lane i word is `in[i*WIDTH +: WIDTH]`.
- `in_valid` in 1: `in` holds a word.
- `in_ready` out 1: a word is accepted at an edge where `in_valid & in_ready`.
- `out` out `LANES`: serial bit per lane, registered.
- `out_s` out 1: registered; high on the first bit of every symbol.
- `out_data` out 1: registered; high on every bit of a data symbol, low on `IDLE` bits.
- `active` out 1: high while in state RUN.

## Operation
- **State machine**, states TRAIN and RUN.
  - Reset puts the block in TRAIN, or in RUN when `TRAIN_SYMS=0`.
  - TRAIN moves to RUN at the edge that emits the last bit of the `TRAIN_SYMS`-th idle symbol.
  - RUN persists until reset.
- **Bit counter** `bcnt`, width `$clog2(WIDTH)`: index of the next bit to emit. It is 0 after reset, increments every edge and wraps from `WIDTH-1` to 0.
- **Symbol selection** happens at every edge where `bcnt==0`:
  - In RUN with the buffer full: each lane's shifter loads its buffered word, `out_data` goes to 1, and the buffer empties.
  - Otherwise: each shifter loads `IDLE` and `out_data` goes to 0.
  - In both cases the first bit is driven onto `out` at that same edge and `out_s` goes to 1.
- **Holding buffer**: one word, `LANES*WIDTH` bits, plus flag `buf_v`.
  - `in_ready = ~reset & (~buf_v | (active & bcnt==0))`.
  - Words may be accepted during TRAIN; they are held until RUN.
- **Simultaneous events**: buffer full, RUN, `bcnt==0` and `in_valid` all at one edge. The buffer drains into the shifter and the new word enters the buffer at that same edge. There is no bubble.
- **No bypass**: an accepted word always passes through the buffer. Every data symbol and every idle symbol is exactly `WIDTH` bits long, with no partial symbols.
- **All lanes** share `bcnt`, `out_s`, `out_data` and `active`.

## Timing
- **Reset values**, held at every edge with `reset=1` (this is also the behaviour when reset is asserted mid-symbol):
  - `out`=0, `out_s`=0, `out_data`=0, `active`=0 (or 1 when `TRAIN_SYMS=0`).
  - `in_ready`=0 while `reset` is high.
  - `bcnt`=0, `buf_v`=0, shifters=`IDLE`, training symbol count=0.
  - A buffered word is discarded.
- **First edge with `reset=0`** (e0): emits bit 0 of the first idle symbol, with `out_s=1`.
- **Latency**: a word accepted at an edge with `bcnt==0` while in RUN and the buffer empty has its first bit on `out` exactly `WIDTH` edges later.
- **Throughput**: one word per `WIDTH` edges.
- **Training symbol count**: saturates at `TRAIN_SYMS`.

## Structure
- **Shared package `ptos_pkg`**: default `COM_SYM=8'hBC`, state enum {TRAIN, RUN}, constant `MAX_LANES=8`.
- **Sub-module `ptos_lane`**, instantiated `LANES` times by generate. It holds one shift register with a load/shift enable and the `MSB_FIRST` mux.
- **Top level**: the FSM, `bcnt`, training count, buffer and handshake.

## Test plan
All scenarios use `WIDTH=8`, `LANES=2`, `TRAIN_SYMS=2`, `MSB_FIRST=1`, and e0 is the first edge with `reset=0`.

1. **Training**: `in_valid=0` after release. Lane0 `out` is 10111100 repeating from e0, `out_s` pulses at e0, e8, e16, …, `out_data` stays 0, and `active` rises after e15.
2. **Early data**: `in=16'hCCEE` with `in_valid=1` from e0, dropped after acceptance. The word is accepted at e0. At e16–e23 lane0 emits 11101110 and lane1 emits 11001100, with `out_data=1`. An idle symbol follows at e24.
3. **Back-to-back**: 16'h1111, 16'h2222 and 16'h3333 offered continuously in RUN. Three consecutive data symbols with no idle between them. `in_ready` is low except at `bcnt==0` edges while the buffer is full.
4. **LSB-first**: `MSB_FIRST=0`, data word 8'hEE. Lane0 emits 01110111 and idle symbols read 00111101.
5. **Mid-symbol reset**: reset asserted at `bcnt==3` of a data symbol with a word buffered. At the next edge all outputs are 0 and `buf_v=0`. After release the training sequence from scenario 1 repeats and the buffered word is never emitted.
6. **Zero training**: `TRAIN_SYMS=0`, word 8'hAA offered at e0. `active=1` during reset. The word is accepted at e0 and its bits 10101010 appear at e8–e15.
